// File: rtl/control_seq.sv
// control_seq -- multi-cycle, bit-sliced control sequencer for the tiny RV32 core.
//
// Accepts one instruction per valid/ready handshake, decodes it into registered
// datapath controls, walks the ALU through NSLICE = XLEN/SLICE_W narrow slices
// while AND-accumulating the per-slice zero flag, then either writes back to
// the register file or resolves a BEQ/BNE branch.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE. instr is
// captured on that edge and never looked at again until the next transfer.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   instr_valid   fetch presents an instruction
//   instr_ready   sequencer can accept (IDLE only)
//   instr         32-bit instruction word
//   slice_zero    ALU result of the current slice is all-zero
//   alu_op        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//   alu_src_imm   operand B comes from the immediate
//   rs1_zero      force operand A to zero (LUI)
//   slice_en      ALU/regfile slice active this cycle
//   slice_idx     current slice, 0 = least significant
//   carry_init    carry-in for slice 0 (SUB only)
//   reg_we        one-cycle write-back strobe
//   branch_taken  one-cycle pulse: load PC with branch target
//   pc_inc        one-cycle pulse: PC += 4
//   done          one-cycle pulse: instruction retired
//   illegal       one-cycle pulse with done for an unsupported encoding
//   state_dbg     current FSM state, for observation only

module control_seq #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8,
  localparam int NSLICE = XLEN / SLICE_W,
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  input  logic          slice_zero,
  output logic [2:0]    alu_op,
  output logic          alu_src_imm,
  output logic          rs1_zero,
  output logic          slice_en,
  output logic [CW-1:0] slice_idx,
  output logic          carry_init,
  output logic          reg_we,
  output logic          branch_taken,
  output logic          pc_inc,
  output logic          done,
  output logic          illegal,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_TRAP   = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  // Only the fields that drive decode are latched; register numbers and
  // immediates are routed to the datapath elsewhere.
  state_t          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic            zero_acc_q, zero_acc_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            alu_src_imm_q, alu_src_imm_d;
  logic            rs1_zero_q, rs1_zero_d;
  logic            is_branch_q, is_branch_d;
  logic            is_bne_q, is_bne_d;

  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Decoder over the latched fields only.
  logic       dec_legal;
  logic [2:0] dec_op;
  logic       dec_imm;
  logic       dec_rs1z;
  logic       dec_branch;
  logic       dec_bne;

  always_comb begin
    dec_legal  = 1'b0;
    dec_op     = OP_ADD;
    dec_imm    = 1'b0;
    dec_rs1z   = 1'b0;
    dec_branch = 1'b0;
    dec_bne    = 1'b0;
    case (opcode_q)
      OPC_OPIMM: begin
        dec_imm = 1'b1;
        case (funct3_q)
          3'b000:  begin dec_legal = 1'b1; dec_op = OP_ADD; end
          3'b111:  begin dec_legal = 1'b1; dec_op = OP_AND; end
          3'b110:  begin dec_legal = 1'b1; dec_op = OP_OR;  end
          3'b100:  begin dec_legal = 1'b1; dec_op = OP_XOR; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        if (funct7_q == 7'b0000000) begin
          case (funct3_q)
            3'b000:  begin dec_legal = 1'b1; dec_op = OP_ADD; end
            3'b111:  begin dec_legal = 1'b1; dec_op = OP_AND; end
            3'b110:  begin dec_legal = 1'b1; dec_op = OP_OR;  end
            3'b100:  begin dec_legal = 1'b1; dec_op = OP_XOR; end
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7_q == 7'b0100000 && funct3_q == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_imm   = 1'b1;
        dec_rs1z  = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3_q == 3'b000 || funct3_q == 3'b001) begin
          dec_legal  = 1'b1;
          dec_op     = OP_SUB;
          dec_branch = 1'b1;
          dec_bne    = funct3_q[0];
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and state-derived outputs.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct3_d      = funct3_q;
    funct7_d      = funct7_q;
    counter_d     = counter_q;
    zero_acc_d    = zero_acc_q;
    alu_op_d      = alu_op_q;
    alu_src_imm_d = alu_src_imm_q;
    rs1_zero_d    = rs1_zero_q;
    is_branch_d   = is_branch_q;
    is_bne_d      = is_bne_q;

    instr_ready   = 1'b0;
    slice_en      = 1'b0;
    carry_init    = 1'b0;
    reg_we        = 1'b0;
    branch_taken  = 1'b0;
    pc_inc        = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opcode_d = instr[6:0];
          funct3_d = instr[14:12];
          funct7_d = instr[31:25];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Illegal encodings leave the controls at a neutral ADD setting.
        alu_op_d      = dec_legal ? dec_op : OP_ADD;
        alu_src_imm_d = dec_legal & dec_imm;
        rs1_zero_d    = dec_legal & dec_rs1z;
        is_branch_d   = dec_legal & dec_branch;
        is_bne_d      = dec_legal & dec_bne;
        zero_acc_d    = 1'b1;
        counter_d     = '0;
        state_d       = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        slice_en   = 1'b1;
        carry_init = (alu_op_q == OP_SUB) && (counter_q == '0);
        zero_acc_d = zero_acc_q & slice_zero;
        if (counter_q == LAST_SLICE) begin
          counter_d = '0;
          state_d   = S_WB;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      S_WB: begin
        done = 1'b1;
        if (is_branch_q) begin
          // BEQ takes on zero difference, BNE on non-zero.
          branch_taken = is_bne_q ^ zero_acc_q;
          pc_inc       = ~(is_bne_q ^ zero_acc_q);
        end else begin
          reg_we = 1'b1;
          pc_inc = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_TRAP: begin
        done    = 1'b1;
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      counter_q     <= '0;
      zero_acc_q    <= 1'b1;
      alu_op_q      <= OP_ADD;
      alu_src_imm_q <= 1'b0;
      rs1_zero_q    <= 1'b0;
      is_branch_q   <= 1'b0;
      is_bne_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct3_q      <= funct3_d;
      funct7_q      <= funct7_d;
      counter_q     <= counter_d;
      zero_acc_q    <= zero_acc_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
      rs1_zero_q    <= rs1_zero_d;
      is_branch_q   <= is_branch_d;
      is_bne_q      <= is_bne_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_src_imm = alu_src_imm_q;
  assign rs1_zero    = rs1_zero_q;
  assign slice_idx   = counter_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed testbench for control_seq with default parameters (NSLICE = 4).
// Inputs change right after a falling edge; outputs are sampled on falling edges.

module tb_control_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic        slice_zero = 1'b0;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        rs1_zero;
  logic        slice_en;
  logic [1:0]  slice_idx;
  logic        carry_init;
  logic        reg_we;
  logic        branch_taken;
  logic        pc_inc;
  logic        done;
  logic        illegal;
  logic [2:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  control_seq dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .slice_zero   (slice_zero),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .rs1_zero     (rs1_zero),
    .slice_en     (slice_en),
    .slice_idx    (slice_idx),
    .carry_init   (carry_init),
    .reg_we       (reg_we),
    .branch_taken (branch_taken),
    .pc_inc       (pc_inc),
    .done         (done),
    .illegal      (illegal),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // All strobes as one vector: {slice_en, carry_init, reg_we, branch_taken, pc_inc, done, illegal}
  function automatic logic [6:0] strobes();
    return {slice_en, carry_init, reg_we, branch_taken, pc_inc, done, illegal};
  endfunction

  // Runs one legal instruction from an IDLE falling edge through to the next IDLE.
  task automatic run_legal(input string name, input logic [31:0] w, input logic [3:0] zp,
                           input logic [2:0] e_op, input logic e_imm, input logic e_rs1z,
                           input logic e_we, input logic e_bt);
    check({name, " idle ready"}, instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = w;
    @(negedge clk);                               // cycle 1: DECODE
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;                  // must be ignored after accept
    check({name, " decode ready"}, instr_ready, 1'b0);
    check({name, " decode strobes"}, strobes(), 7'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);                             // cycles 2..5: EXEC
      check({name, " exec slice_en"}, slice_en, 1'b1);
      check({name, " exec slice_idx"}, slice_idx, k[1:0]);
      check({name, " exec carry_init"}, carry_init, (e_op == 3'b001) && (k == 0));
      check({name, " exec alu_op"}, alu_op, e_op);
      check({name, " exec alu_src_imm"}, alu_src_imm, e_imm);
      check({name, " exec rs1_zero"}, rs1_zero, e_rs1z);
      check({name, " exec done"}, done, 1'b0);
      slice_zero = zp[k];
    end
    @(negedge clk);                               // cycle 6: WB
    slice_zero = 1'b0;
    check({name, " wb slice_en"}, slice_en, 1'b0);
    check({name, " wb done"}, done, 1'b1);
    check({name, " wb reg_we"}, reg_we, e_we);
    check({name, " wb branch_taken"}, branch_taken, e_bt);
    check({name, " wb pc_inc"}, pc_inc, !e_bt);
    check({name, " wb illegal"}, illegal, 1'b0);
    @(negedge clk);                               // cycle 7: IDLE
    check({name, " retire ready"}, instr_ready, 1'b1);
    check({name, " retire strobes"}, strobes(), 7'b0);
  endtask

  initial begin
    int done_c1;
    int done_c2;

    // reset state
    repeat (2) @(negedge clk);
    check("reset ready", instr_ready, 1'b1);
    check("reset strobes", strobes(), 7'b0);
    check("reset alu_op", alu_op, 3'b000);
    check("reset imm/rs1z", {alu_src_imm, rs1_zero}, 2'b00);
    check("reset slice_idx", slice_idx, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset during EXEC slice 2
    instr_valid = 1'b1;
    instr       = 32'h0050_0093;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);                    // EXEC slice 2
    check("pre-reset slice_idx", slice_idx, 2'd2);
    rst = 1'b1;
    #1;
    check("async reset ready", instr_ready, 1'b1);
    @(negedge clk);
    check("reset mid-exec ready", instr_ready, 1'b1);
    check("reset mid-exec strobes", strobes(), 7'b0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post-reset quiet", strobes(), 7'b0);
    end

    run_legal("addi after reset", 32'h0050_0093, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_legal("sub",     32'h4020_81B3, 4'b0000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    run_legal("beq eq",  32'h0020_8063, 4'b1111, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_legal("beq ne",  32'h0020_8063, 4'b0111, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_legal("bne eq",  32'h0020_9063, 4'b1111, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_legal("bne ne",  32'h0020_9063, 4'b0111, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_legal("beq lo0", 32'h0020_8063, 4'b1110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_legal("lui",     32'h1234_52B7, 4'b0000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    run_legal("and",     32'h0020_F1B3, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    run_legal("or",      32'h0020_E1B3, 4'b0000, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
    run_legal("ori",     32'h0050_E093, 4'b0000, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
    run_legal("xori",    32'h0050_C093, 4'b0000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0);

    // illegal encodings: TRAP in cycle 2, IDLE in cycle 3
    for (int t = 0; t < 3; t++) begin
      logic [31:0] bad;
      case (t)
        0:       bad = 32'h0000_007F;              // unknown opcode
        1:       bad = 32'h4020_F1B3;              // funct7 0100000 with AND funct3
        default: bad = 32'h0020_A063;              // BRANCH funct3 010
      endcase
      check("illegal idle ready", instr_ready, 1'b1);
      instr_valid = 1'b1;
      instr       = bad;
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 32'h0050_0093;                 // legal word after accept is ignored
      check("illegal decode strobes", strobes(), 7'b0);
      @(negedge clk);
      check("trap strobes", strobes(), 7'b0000011);
      check("trap ready", instr_ready, 1'b0);
      @(negedge clk);
      check("trap exit ready", instr_ready, 1'b1);
      check("trap exit strobes", strobes(), 7'b0);
    end

    // instr_valid held high: second accept on the first IDLE cycle
    done_c1 = -1;
    done_c2 = -1;
    instr_valid = 1'b1;
    instr       = 32'h0050_0093;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        if (done_c1 < 0) done_c1 = c;
        else if (done_c2 < 0) done_c2 = c;
      end
      if (c == 7) check("b2b idle ready", instr_ready, 1'b1);
      if (c == 8) check("b2b decode ready", instr_ready, 1'b0);
    end
    instr_valid = 1'b0;
    check("b2b first done cycle", done_c1, 6);
    check("b2b second done cycle", done_c2, 13);
    check("b2b final ready", instr_ready, 1'b1);
    @(negedge clk);
    check("b2b drained", instr_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
